// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, iteration count and the operand magnitude helper.
package mult_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int unsigned MD_ITER_COUNT = 32;
    localparam logic [4:0]  MD_CNT_LOAD   = 5'(MD_ITER_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Magnitude of a value; unsigned operations pass the value through.
    function automatic logic [31:0] md_mag(input logic [31:0] value, input logic is_signed);
        if (is_signed && value[31]) begin
            md_mag = 32'd0 - value;
        end else begin
            md_mag = value;
        end
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: shift-add multiply step or restoring divide
// step on a 64-bit accumulator ({hi, lo} product or {remainder, quotient}).
module mult_div_step
    import mult_div_unit_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  logic        is_div,
    output logic [63:0] acc_next,
    output logic        q_bit
);

    logic [32:0] sum_s;
    logic [32:0] shifted_rem_s;
    logic [32:0] diff_s;

    // Multiply adds the multiplicand into hi when lo[0] is set and shifts right;
    // divide shifts the next dividend bit into the 33-bit partial remainder and
    // keeps the trial subtraction when it does not borrow.
    always_comb begin
        sum_s         = {1'b0, acc[63:32]} + {1'b0, operand};
        shifted_rem_s = acc[63:31];
        diff_s        = shifted_rem_s - {1'b0, operand};
        acc_next      = 64'd0;
        q_bit         = 1'b0;
        if (is_div) begin
            if (!diff_s[32]) begin
                acc_next = {diff_s[31:0], acc[30:0], 1'b0};
                q_bit    = 1'b1;
            end else begin
                acc_next = {shifted_rem_s[31:0], acc[30:0], 1'b0};
                q_bit    = 1'b0;
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum_s, acc[31:1]};
            end else begin
                acc_next = {1'b0, acc[63:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit writing hi/lo through a one-cycle
// strobe; busy stalls dependent instructions until the result is written.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        cancel,
    output logic        busy,
    output logic        control_hilo_write,
    output logic [31:0] reg_hi_w,
    output logic [31:0] reg_lo_w
);

    md_state_e   state_r;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;
    logic [31:0] operand_r;
    logic        is_div_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [63:0] step_acc_s;
    logic        q_bit_s;
    logic [63:0] next_acc_s;
    logic [63:0] neg_acc_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;
    logic        is_signed_s;
    logic        is_div_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        div_zero_s;

    mult_div_step u_step (
        .acc      (acc_r),
        .operand  (operand_r),
        .is_div   (is_div_r),
        .acc_next (step_acc_s),
        .q_bit    (q_bit_s)
    );

    assign is_signed_s = (op == MD_MULT) || (op == MD_DIV);
    assign is_div_s    = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg_s     = is_signed_s & operand_a[31];
    assign b_neg_s     = is_signed_s & operand_b[31];
    assign div_zero_s  = is_div_s && (operand_b == 32'd0);
    assign next_acc_s  = step_acc_s | {63'd0, q_bit_s};
    assign neg_acc_s   = 64'd0 - next_acc_s;

    // Sign fixup of the final step's result, captured into hi_r/lo_r on entry to DONE.
    always_comb begin
        fix_hi_s = next_acc_s[63:32];
        fix_lo_s = next_acc_s[31:0];
        if (is_div_r) begin
            fix_hi_s = neg_r_r ? (32'd0 - next_acc_s[63:32]) : next_acc_s[63:32];
            fix_lo_s = neg_q_r ? (32'd0 - next_acc_s[31:0]) : next_acc_s[31:0];
        end else if (neg_q_r) begin
            fix_hi_s = neg_acc_s[63:32];
            fix_lo_s = neg_acc_s[31:0];
        end else begin
            fix_hi_s = next_acc_s[63:32];
            fix_lo_s = next_acc_s[31:0];
        end
    end

    // Control FSM with counter, operand/sign latches and result registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            acc_r     <= 64'd0;
            operand_r <= 32'd0;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else if (cancel) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        is_div_r <= is_div_s;
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        cnt_r    <= MD_CNT_LOAD;
                        // Multiply shifts the multiplier out of lo; divide shifts the dividend out.
                        if (is_div_s) begin
                            acc_r     <= {32'd0, md_mag(operand_a, is_signed_s)};
                            operand_r <= md_mag(operand_b, is_signed_s);
                        end else begin
                            acc_r     <= {32'd0, md_mag(operand_b, is_signed_s)};
                            operand_r <= md_mag(operand_a, is_signed_s);
                        end
                        if (div_zero_s) begin
                            hi_r    <= operand_a;
                            lo_r    <= 32'hFFFF_FFFF;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_r <= next_acc_s;
                    if (cnt_r == 5'd0) begin
                        hi_r    <= fix_hi_s;
                        lo_r    <= fix_lo_s;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r - 5'd1;
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy               = (state_r != ST_IDLE);
    assign control_hilo_write = (state_r == ST_DONE) & ~cancel;
    assign reg_hi_w           = hi_r;
    assign reg_lo_w           = lo_r;

endmodule
